snake_body_update: RTL and testbench
====================================

// Module: snake_body_update
// PURPOSE
//  Writer side of the snake body array: owns body[] and curr_length, which the display-side
//  location check reads. On each game step it advances the head in the latched direction and
//  shifts the body one slot. Grow requests lengthen the snake. A serial scan detects wall and
//  self-collision and reports death.
// PARAMETERS
//  MAX_LENGTH  50     body array depth; slot 0 = head, slots 1..curr_length = body
//  INIT_LEN    2      body segments after reset/restart (requires START_POS[7:4] >= INIT_LEN)
//  START_POS   8'h77  initial head coordinate, {x[3:0], y[3:0]} on a 16x16 grid
// PORTS
//  clk          in   1                 system clock
//  rst          in   1                 asynchronous reset, active-high
//  step         in   1                 one-cycle move strobe from game tick
//  dir          in   2                 requested direction: 00 UP(y-1) 01 DOWN(y+1) 10 LEFT(x-1) 11 RIGHT(x+1)
//  grow         in   1                 sampled with step: lengthen by one this move
//  restart      in   1                 return to initial snake from any state
//  body         out  MAX_LENGTH x 8    segment coordinates; [0] = head
//  curr_length  out  7                 number of body segments excluding head
//  busy         out  1                 high while move/scan in progress; step ignored
//  dead         out  1                 sticky wall/self collision flag
//  moved        out  1                 one-cycle pulse: move completed without collision
// BEHAVIOUR
//  Reset/restart values:
//   - body[0]=START_POS; body[i]=START_POS - {i[3:0],4'h0} for i=1..INIT_LEN (trail to the left).
//   - All other slots are 8'h00. curr_length=INIT_LEN. cur_dir=RIGHT. busy=dead=moved=0.
//   - FSM goes to IDLE.
//  Direction:
//   - dir is sampled only on an accepted step.
//   - If dir == cur_dir ^ 2'b01 (reversal), the request is ignored and cur_dir is kept.
//  FSM states: IDLE, SCAN, DEAD.
//   - IDLE, step=1 -> compute next_head from body[0] and the effective direction.
//   - Wall case: next_head would leave 0..15 on either axis (no wrap).
//     -> DEAD on the next edge; body and curr_length unchanged; moved not pulsed.
//   - Otherwise, on the same edge:
//     - body[0] <= next_head; body[i] <= body[i-1] for i=1..MAX_LENGTH-1.
//     - If grow=1 and curr_length < MAX_LENGTH-1, curr_length increments. The new tail is
//       the old tail position. At max length, growth saturates silently.
//     - cur_dir updates. State -> SCAN with k=1.
//   - SCAN: one compare per cycle of body[k] vs body[0], k = 1..curr_length (new length).
//     - Hit -> DEAD next edge.
//     - k == curr_length with no hit -> IDLE; moved=1 for exactly that next cycle.
//     - Scan takes curr_length cycles. busy=1 throughout SCAN.
//     - A head entering the cell the tail just vacated is legal (compare uses post-shift body).
//   - DEAD: dead=1, body frozen, step ignored.
//  restart has priority over step in every state; the reinit is visible the next cycle.
//  step during SCAN or DEAD is dropped (no queuing).
//  rst asserted mid-SCAN -> immediate reset values; no moved pulse.
//  All outputs are registered. body is never partially updated within a cycle.
// STRUCTURE
//  - snake_pkg: dir_t enum (UP/DOWN/LEFT/RIGHT), coord_t (8-bit {x,y}),
//    MAX_LENGTH default, opposite() function.
//  - Sub-module snake_next_head (combinational): body[0], dir -> next_head, wall_hit.
//  - Top level holds the FSM, shift array, scan counter and length register.
// TESTING
//  1. Reset -> body[0]=77, [1]=67, [2]=57, curr_length=2, busy=dead=moved=0.
//  2. step dir=RIGHT grow=0 -> body[0..2]=87,77,67; busy 2 cycles; moved pulse once.
//  3. From reset, step dir=LEFT -> reversal ignored; head moves to 87.
//  4. step RIGHT grow=1 twice -> curr_length=4; body[0..4]=97,87,77,67,57.
//     Then step UP, LEFT, DOWN -> head 87 matches body[4]; dead=1; no moved on last step.
//  5. Steer head to x=F, step RIGHT -> dead=1 next cycle, body unchanged.
//     Further step ignored. restart -> test 1 values.
//  6. rst pulse mid-SCAN -> reset values at once, no moved.
//     restart and step in the same cycle -> restart wins.

Source files
------------

// File: rtl/snake_body_update_pkg.sv
// Shared types and helpers for the snake body writer: directions, coordinates, FSM states.
package snake_body_update_pkg;
  localparam int MAX_LENGTH_DEF = 50;

  typedef enum logic [1:0] {UP = 2'b00, DOWN = 2'b01, LEFT = 2'b10, RIGHT = 2'b11} dir_t;
  typedef logic [7:0] coord_t;  // {x[3:0], y[3:0]}
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DEAD} state_t;

  // Encoding pairs opposites so that they differ only in bit 0.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction
endpackage

// File: rtl/snake_body_update_if.sv
// Game-side bus for the snake body writer: move request in, body array and status out.
interface snake_body_update_if
  import snake_body_update_pkg::*;
#(parameter int MAX_LENGTH = MAX_LENGTH_DEF);
  logic                        step;
  logic [1:0]                  dir;
  logic                        grow;
  logic                        restart;
  logic [MAX_LENGTH-1:0][7:0]  body;
  logic [6:0]                  curr_length;
  logic                        busy;
  logic                        dead;
  logic                        moved;

  modport master (output step, dir, grow, restart,
                  input  body, curr_length, busy, dead, moved);
  modport slave  (input  step, dir, grow, restart,
                  output body, curr_length, busy, dead, moved);
endinterface

// File: rtl/snake_body_update_next_head.sv
// Combinational head advance on the 16x16 grid; flags a move that would leave the grid.
module snake_next_head
  import snake_body_update_pkg::*;
(
  input  coord_t i_head,
  input  dir_t   i_dir,
  output coord_t o_next_head,
  output logic   o_wall_hit
);
  logic [3:0] w_x, w_y, w_nx, w_ny;

  assign w_x = i_head[7:4];
  assign w_y = i_head[3:0];

  always_comb begin
    w_nx       = w_x;
    w_ny       = w_y;
    o_wall_hit = 1'b0;
    unique case (i_dir)
      UP:    begin o_wall_hit = (w_y == 4'h0); w_ny = w_y - 4'd1; end
      DOWN:  begin o_wall_hit = (w_y == 4'hF); w_ny = w_y + 4'd1; end
      LEFT:  begin o_wall_hit = (w_x == 4'h0); w_nx = w_x - 4'd1; end
      RIGHT: begin o_wall_hit = (w_x == 4'hF); w_nx = w_x + 4'd1; end
    endcase
  end

  assign o_next_head = {w_nx, w_ny};
endmodule

// File: rtl/snake_body_update.sv
// Snake body writer: shifts the body on each step, then scans serially for self-collision.
module snake_body_update
  import snake_body_update_pkg::*;
#(
  parameter int          MAX_LENGTH = MAX_LENGTH_DEF,
  parameter int          INIT_LEN   = 2,
  parameter logic [7:0]  START_POS  = 8'h77
) (
  input  logic               clk,
  input  logic               rst,
  snake_body_update_if.slave bus
);
  localparam int IDX_W = $clog2(MAX_LENGTH);
  typedef logic [MAX_LENGTH-1:0][7:0] body_t;

  // Initial snake trails to the left of the head; unused slots are zero.
  function automatic body_t init_body();
    body_t b;
    b = '0;
    for (int i = 0; i <= INIT_LEN; i++) b[i] = START_POS - {i[3:0], 4'h0};
    return b;
  endfunction

  localparam body_t INIT_BODY = init_body();

  state_t     r_state;
  body_t      r_body;
  logic [6:0] r_len;
  logic [6:0] r_k;
  dir_t       r_dir;
  logic       r_busy, r_dead, r_moved;

  dir_t   w_dir_req, w_eff_dir;
  coord_t w_next_head;
  logic   w_wall, w_hit;

  assign w_dir_req = dir_t'(bus.dir);
  assign w_eff_dir = (w_dir_req == opposite(r_dir)) ? r_dir : w_dir_req;

  snake_next_head u_next_head (
    .i_head      (r_body[0]),
    .i_dir       (w_eff_dir),
    .o_next_head (w_next_head),
    .o_wall_hit  (w_wall)
  );

  // Scan compares the already-shifted body, so chasing the tail is legal.
  assign w_hit = (r_body[r_k[IDX_W-1:0]] == r_body[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_body  <= INIT_BODY;
      r_len   <= 7'(INIT_LEN);
      r_k     <= 7'd1;
      r_dir   <= RIGHT;
      r_busy  <= 1'b0;
      r_dead  <= 1'b0;
      r_moved <= 1'b0;
    end else begin
      r_moved <= 1'b0;
      if (bus.restart) begin
        r_state <= S_IDLE;
        r_body  <= INIT_BODY;
        r_len   <= 7'(INIT_LEN);
        r_k     <= 7'd1;
        r_dir   <= RIGHT;
        r_busy  <= 1'b0;
        r_dead  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.step) begin
              if (w_wall) begin
                r_state <= S_DEAD;
                r_dead  <= 1'b1;
              end else begin
                r_body <= {r_body[MAX_LENGTH-2:0], w_next_head};
                if (bus.grow && (r_len < 7'(MAX_LENGTH-1))) r_len <= r_len + 7'd1;
                r_dir   <= w_eff_dir;
                r_k     <= 7'd1;
                r_busy  <= 1'b1;
                r_state <= S_SCAN;
              end
            end
          end
          S_SCAN: begin
            if (w_hit) begin
              r_state <= S_DEAD;
              r_busy  <= 1'b0;
              r_dead  <= 1'b1;
            end else if (r_k == r_len) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_moved <= 1'b1;
            end else begin
              r_k <= r_k + 7'd1;
            end
          end
          S_DEAD:  r_dead  <= 1'b1;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.body        = r_body;
  assign bus.curr_length = r_len;
  assign bus.busy        = r_busy;
  assign bus.dead        = r_dead;
  assign bus.moved       = r_moved;
endmodule

// File: tb/tb_snake_body_update.sv
// Bench for snake_body_update: directed scenarios plus random moves against a grid-level model.
module tb_snake_body_update;
  import snake_body_update_pkg::*;

  localparam int MAXL = 50;
  typedef logic [MAXL-1:0][7:0] body_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snake_body_update_if #(.MAX_LENGTH(MAXL)) bus ();

  snake_body_update #(.MAX_LENGTH(MAXL), .INIT_LEN(2), .START_POS(8'h77)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    n_err = 0;
  int    n_chk = 0;
  body_t m_body;
  int    m_len;
  logic [1:0] m_dir;
  bit    m_dead;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_init();
    m_body = '0;
    for (int i = 0; i <= 2; i++) m_body[i] = 8'h77 - 8'(16 * i);
    m_len  = 2;
    m_dir  = 2'b11;
    m_dead = 0;
  endfunction

  task automatic do_reset();
    bus.step = 0; bus.grow = 0; bus.restart = 0; bus.dir = 2'b00;
    rst = 1;
    #3;
    rst = 0;
    tick();
    model_init();
  endtask

  task automatic do_restart();
    bus.restart = 1;
    tick();
    bus.restart = 0;
    model_init();
    n_chk++;
    if (bus.body !== m_body) begin
      n_err++; $display("FAIL restart_body got=%h exp=%h", bus.body, m_body);
    end
    n_chk++;
    if ({bus.curr_length, bus.busy, bus.dead, bus.moved} !== {7'd2, 3'b000}) begin
      n_err++; $display("FAIL restart_state got len=%0d bdm=%b%b%b exp len=2 bdm=000",
                        bus.curr_length, bus.busy, bus.dead, bus.moved);
    end
  endtask

  // One move: the model works on x/y integers, then the DUT is held to the exact scan timing.
  task automatic do_step(input logic [1:0] d, input bit g, input bit junk);
    logic [1:0] ed;
    int x, y, hk, nend;
    bit wall, rev;
    if (m_dead) return;
    rev = (d == 2'd0 && m_dir == 2'd1) || (d == 2'd1 && m_dir == 2'd0) ||
          (d == 2'd2 && m_dir == 2'd3) || (d == 2'd3 && m_dir == 2'd2);
    ed = rev ? m_dir : d;
    x = int'(m_body[0][7:4]);
    y = int'(m_body[0][3:0]);
    case (ed)
      2'd0: y = y - 1;
      2'd1: y = y + 1;
      2'd2: x = x - 1;
      default: x = x + 1;
    endcase
    wall = (x < 0) || (x > 15) || (y < 0) || (y > 15);
    hk = 0;
    if (!wall) begin
      for (int i = MAXL - 1; i > 0; i--) m_body[i] = m_body[i-1];
      m_body[0] = {x[3:0], y[3:0]};
      if (g && m_len < MAXL - 1) m_len++;
      m_dir = ed;
      for (int k = 1; k <= m_len; k++)
        if (hk == 0 && m_body[k] == m_body[0]) hk = k;
    end

    bus.step = 1; bus.dir = d; bus.grow = g;
    tick();
    bus.step = 0; bus.grow = 0;

    n_chk++;
    if (bus.body !== m_body || bus.curr_length !== 7'(m_len)) begin
      n_err++; $display("FAIL step_body got=%h len=%0d exp=%h len=%0d",
                        bus.body, bus.curr_length, m_body, m_len);
    end
    n_chk++;
    if ({bus.busy, bus.dead, bus.moved} !== (wall ? 3'b010 : 3'b100)) begin
      n_err++; $display("FAIL step_flags got bdm=%b%b%b exp=%b", bus.busy, bus.dead, bus.moved,
                        wall ? 3'b010 : 3'b100);
    end
    if (wall) begin
      m_dead = 1;
      return;
    end

    nend = (hk != 0) ? hk : m_len;
    for (int c = 1; c <= nend; c++) begin
      if (junk) begin
        bus.step = 1'($urandom_range(0, 1));
        bus.dir  = 2'($urandom_range(0, 3));
      end
      tick();
      bus.step = 0;
      n_chk++;
      if (c < nend) begin
        if ({bus.busy, bus.dead, bus.moved} !== 3'b100) begin
          n_err++; $display("FAIL scan_busy cyc=%0d got bdm=%b%b%b exp=100", c,
                            bus.busy, bus.dead, bus.moved);
        end
      end else begin
        if ({bus.busy, bus.dead, bus.moved} !== ((hk != 0) ? 3'b010 : 3'b001)) begin
          n_err++; $display("FAIL scan_end cyc=%0d got bdm=%b%b%b exp=%b", c,
                            bus.busy, bus.dead, bus.moved, (hk != 0) ? 3'b010 : 3'b001);
        end
      end
    end
    n_chk++;
    if (bus.body !== m_body) begin
      n_err++; $display("FAIL scan_body_stable got=%h exp=%h", bus.body, m_body);
    end
    if (hk != 0) begin
      m_dead = 1;
    end else begin
      tick();
      n_chk++;
      if ({bus.busy, bus.moved} !== 2'b00) begin
        n_err++; $display("FAIL moved_pulse got busy=%b moved=%b exp 0 0", bus.busy, bus.moved);
      end
    end
  endtask

  task automatic test_reset();
    body_t e;
    rst = 1; bus.step = 0; bus.grow = 0; bus.restart = 0; bus.dir = 2'b00;
    #12;
    rst = 0;
    tick();
    model_init();
    e = '0; e[0] = 8'h77; e[1] = 8'h67; e[2] = 8'h57;
    n_chk++;
    if (bus.body !== e) begin
      n_err++; $display("FAIL reset_body got=%h exp=%h", bus.body, e);
    end
    n_chk++;
    if ({bus.curr_length, bus.busy, bus.dead, bus.moved} !== {7'd2, 3'b000}) begin
      n_err++; $display("FAIL reset_state got len=%0d bdm=%b%b%b exp len=2 bdm=000",
                        bus.curr_length, bus.busy, bus.dead, bus.moved);
    end
  endtask

  task automatic test_move();
    do_reset();
    do_step(2'b11, 0, 0);
    n_chk++;
    if ({bus.body[0], bus.body[1], bus.body[2]} !== 24'h87_77_67) begin
      n_err++; $display("FAIL move_right got=%h %h %h exp=87 77 67",
                        bus.body[0], bus.body[1], bus.body[2]);
    end
  endtask

  task automatic test_reversal();
    do_reset();
    do_step(2'b10, 0, 0);
    n_chk++;
    if (bus.body[0] !== 8'h87) begin
      n_err++; $display("FAIL reversal_head got=%h exp=87", bus.body[0]);
    end
  endtask

  task automatic test_self_collision();
    body_t e;
    do_reset();
    do_step(2'b11, 1, 0);
    do_step(2'b11, 1, 0);
    e = '0; e[0] = 8'h97; e[1] = 8'h87; e[2] = 8'h77; e[3] = 8'h67; e[4] = 8'h57;
    n_chk++;
    if (bus.body[4:0] !== e[4:0] || bus.curr_length !== 7'd4) begin
      n_err++; $display("FAIL grow_two got=%h len=%0d exp=%h len=4",
                        bus.body[4:0], bus.curr_length, e[4:0]);
    end
    do_step(2'b00, 0, 0);
    do_step(2'b10, 0, 0);
    do_step(2'b01, 0, 0);
    n_chk++;
    if ({bus.dead, bus.moved, bus.body[0], bus.body[4]} !== {2'b10, 8'h87, 8'h87}) begin
      n_err++; $display("FAIL self_hit got dead=%b moved=%b head=%h b4=%h exp 1 0 87 87",
                        bus.dead, bus.moved, bus.body[0], bus.body[4]);
    end
  endtask

  task automatic test_wall();
    do_reset();
    repeat (8) do_step(2'b11, 0, 0);
    n_chk++;
    if (bus.body[0] !== 8'hF7) begin
      n_err++; $display("FAIL wall_approach got=%h exp=f7", bus.body[0]);
    end
    do_step(2'b11, 0, 0);
    bus.step = 1; bus.dir = 2'b00;
    tick();
    bus.step = 0;
    tick();
    n_chk++;
    if (bus.body !== m_body || bus.dead !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL dead_frozen got=%h dead=%b busy=%b exp=%h dead=1 busy=0",
                        bus.body, bus.dead, bus.busy, m_body);
    end
    do_restart();
  endtask

  task automatic test_rst_mid_scan();
    do_reset();
    bus.step = 1; bus.dir = 2'b11;
    tick();
    bus.step = 0;
    n_chk++;
    if (bus.busy !== 1'b1) begin
      n_err++; $display("FAIL mid_scan_busy got=%b exp=1", bus.busy);
    end
    rst = 1;
    #1;
    model_init();
    n_chk++;
    if (bus.body !== m_body || {bus.curr_length, bus.busy, bus.dead, bus.moved} !== {7'd2, 3'b000}) begin
      n_err++; $display("FAIL async_rst got=%h len=%0d bdm=%b%b%b exp=%h len=2 bdm=000",
                        bus.body, bus.curr_length, bus.busy, bus.dead, bus.moved, m_body);
    end
    #2;
    rst = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_chk++;
      if ({bus.busy, bus.moved} !== 2'b00) begin
        n_err++; $display("FAIL post_rst_quiet cyc=%0d got busy=%b moved=%b exp 0 0",
                          c, bus.busy, bus.moved);
      end
    end
  endtask

  task automatic test_restart_priority();
    do_reset();
    do_step(2'b11, 1, 0);
    bus.restart = 1; bus.step = 1; bus.dir = 2'b00;
    tick();
    bus.restart = 0; bus.step = 0;
    model_init();
    n_chk++;
    if (bus.body !== m_body || {bus.curr_length, bus.busy, bus.dead} !== {7'd2, 2'b00}) begin
      n_err++; $display("FAIL restart_wins got=%h len=%0d busy=%b dead=%b exp=%h len=2 0 0",
                        bus.body, bus.curr_length, bus.busy, bus.dead, m_body);
    end
    tick();
    n_chk++;
    if (bus.body !== m_body || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL restart_no_step got=%h busy=%b exp=%h busy=0",
                        bus.body, bus.busy, m_body);
    end
  endtask

  // Serpentine path that never touches itself, growing every step into saturation.
  task automatic test_saturation();
    logic [1:0] path[$];
    do_reset();
    repeat (8)  path.push_back(2'b11);
    repeat (7)  path.push_back(2'b00);
    repeat (15) path.push_back(2'b10);
    path.push_back(2'b01);
    repeat (14) path.push_back(2'b11);
    path.push_back(2'b01);
    repeat (6)  path.push_back(2'b10);
    foreach (path[i]) do_step(path[i], 1, 1);
    n_chk++;
    if (bus.curr_length !== 7'd49 || bus.dead !== 1'b0) begin
      n_err++; $display("FAIL saturate got len=%0d dead=%b exp len=49 dead=0",
                        bus.curr_length, bus.dead);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 300; n++) begin
      if (m_dead || $urandom_range(0, 19) == 0) do_restart();
      else do_step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1);
    end
  endtask

  initial begin
    test_reset();
    test_move();
    test_reversal();
    test_self_collision();
    test_wall();
    test_rst_mid_scan();
    test_restart_priority();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
